// File: rtl/irq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// irq_ctrl_pkg : shared types and constants for the interrupt controller
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package irq_ctrl_pkg;

  localparam int unsigned ID_W = 6;

  localparam logic [1:0] OFF_PENDING = 2'd0;
  localparam logic [1:0] OFF_ENABLE  = 2'd1;
  localparam logic [1:0] OFF_CLAIM   = 2'd2;
  localparam logic [1:0] OFF_STATUS  = 2'd3;

  localparam logic [31:0] ADR_LAST = 32'h0000_000C;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PEND    = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } wb_req_t;

  typedef struct packed {
    logic        ack;
    logic        err;
    logic [31:0] dat;
  } wb_rsp_t;

  function automatic logic [31:0] sel_to_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

`default_nettype wire

// File: rtl/irq_prio_enc.sv
// ---------------------------------------------------------------------------
// irq_prio_enc : lowest-index-first priority encoder, returns {valid, index+1}
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module irq_prio_enc
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned N_SRC = 8
) (
  input  logic [N_SRC-1:0] req_i,
  output logic             valid_o,
  output logic [ID_W-1:0]  id_o
);

  // Scan from the top down so the lowest set index is the last to write.
  always_comb begin
    valid_o = 1'b0;
    id_o    = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        id_o    = ID_W'(i + 1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/irq_ctrl.sv
// ---------------------------------------------------------------------------
// irq_ctrl : edge-capturing interrupt controller with claim/complete over WB
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned N_SRC = 8
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic [N_SRC-1:0] src_i,
  output logic             irq_o,
  input  wb_req_t          wb_req_i,
  output wb_rsp_t          wb_rsp_o
);

  logic [N_SRC-1:0] src_q;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] enable_q, enable_d;
  logic [ID_W-1:0]  claimed_q, claimed_d;
  irq_state_e       state_q, state_d;

  logic             access;
  logic             adr_ok;
  logic             rd;
  logic             wr;
  logic [1:0]       off;
  logic [31:0]      lane32;
  logic [N_SRC-1:0] lane;
  logic [N_SRC-1:0] wdat;
  logic [N_SRC-1:0] active;
  logic             act_valid;
  logic [ID_W-1:0]  act_id;
  logic             claim_rd;
  logic             complete;
  logic [N_SRC-1:0] edges;
  logic [N_SRC-1:0] w1c;
  logic [N_SRC-1:0] claim_clr;
  logic             unused_bits;

  assign access = wb_req_i.cyc & wb_req_i.stb;
  assign adr_ok = (wb_req_i.adr <= ADR_LAST);
  assign rd     = access & ~wb_req_i.we & adr_ok;
  assign wr     = access & wb_req_i.we & adr_ok;
  assign off    = wb_req_i.adr[3:2];
  assign lane32 = sel_to_mask(wb_req_i.sel);
  assign lane   = lane32[N_SRC-1:0];
  assign wdat   = wb_req_i.dat[N_SRC-1:0];

  assign unused_bits = ^wb_req_i.dat;

  assign active = pending_q & enable_q;

  irq_prio_enc #(
    .N_SRC (N_SRC)
  ) u_prio (
    .req_i   (active),
    .valid_o (act_valid),
    .id_o    (act_id)
  );

  assign claim_rd = rd && (off == OFF_CLAIM) && (state_q == PEND) && act_valid;
  assign complete = wr && (off == OFF_CLAIM) && (state_q == SERVICE) &&
                    (wb_req_i.dat[ID_W-1:0] == claimed_q);

  assign edges = src_i & ~src_q;
  assign w1c   = (wr && (off == OFF_PENDING)) ? (wdat & lane) : '0;
  // Isolating the lowest set bit of active is exactly the claimed source.
  assign claim_clr = claim_rd ? (active & ~(active - N_SRC'(1))) : '0;

  // A new edge is ORed in last so it survives both W1C and a same-cycle claim.
  assign pending_d = (pending_q & ~w1c & ~claim_clr) | edges;

  always_comb begin
    enable_d = enable_q;
    if (wr && (off == OFF_ENABLE)) begin
      enable_d = (enable_q & ~lane) | (wdat & lane);
    end
  end

  always_comb begin
    claimed_d = claimed_q;
    if (claim_rd) begin
      claimed_d = act_id;
    end else if (complete) begin
      claimed_d = '0;
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q   <= IDLE;
      src_q     <= '0;
      pending_q <= '0;
      enable_q  <= '0;
      claimed_q <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_i;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      claimed_q <= claimed_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (act_valid) state_d = PEND;
      end
      PEND: begin
        if (claim_rd)        state_d = SERVICE;
        else if (!act_valid) state_d = IDLE;
      end
      SERVICE: begin
        if (complete) state_d = act_valid ? PEND : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    irq_o = (state_q == PEND);
  end

  always_comb begin
    wb_rsp_o.ack = access;
    wb_rsp_o.err = access & ~adr_ok;
    wb_rsp_o.dat = '0;
    if (rd) begin
      unique case (off)
        OFF_PENDING: wb_rsp_o.dat = 32'(pending_q);
        OFF_ENABLE:  wb_rsp_o.dat = 32'(enable_q);
        OFF_CLAIM:   wb_rsp_o.dat = (state_q == PEND) ? 32'(act_id) : 32'd0;
        OFF_STATUS:  wb_rsp_o.dat = {29'b0, state_q, (state_q == PEND)};
        default:     wb_rsp_o.dat = '0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_irq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_irq_ctrl : scoreboard bench for irq_ctrl with a behavioural reference model
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [N-1:0] src_i;
  logic        irq_o;
  wb_req_t     req;
  wb_rsp_t     rsp;

  always #5 clk = ~clk;

  irq_ctrl #(.N_SRC(N)) dut (
    .clk      (clk),
    .rst_i    (rst_i),
    .src_i    (src_i),
    .irq_o    (irq_o),
    .wb_req_i (req),
    .wb_rsp_o (rsp)
  );

  typedef struct {
    logic        err;
    logic [31:0] dat;
  } exp_t;

  exp_t rsp_q[$];
  logic irq_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: state 0 = idle, 1 = waiting for claim, 2 = being serviced
  logic [N-1:0] m_pend, m_en, m_prev;
  int           m_claimed;
  int           m_state;

  function automatic int lowest_id(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i + 1;
    return 0;
  endfunction

  task automatic tick();
    exp_t         e;
    logic [N-1:0] act, edges, w1c, clr, s;
    logic [31:0]  lane, d, a;
    logic         acc, ok, we, claim, complete;
    int           id, off;
    logic [1:0]   st2;
    act  = m_pend & m_en;
    id   = lowest_id(act);
    acc  = req.cyc & req.stb;
    a    = req.adr;
    ok   = (a <= 32'hC);
    we   = req.we;
    off  = int'(a[3:2]);
    d    = req.dat;
    s    = src_i;
    lane = '0;
    for (int b = 0; b < 4; b++) if (req.sel[b]) lane[8*b +: 8] = 8'hFF;
    irq_q.push_back(m_state == 1);
    if (acc) begin
      e.err = !ok;
      e.dat = 32'd0;
      if (ok && !we) begin
        st2 = 2'(m_state);
        case (off)
          0: e.dat = 32'(m_pend);
          1: e.dat = 32'(m_en);
          2: e.dat = (m_state == 1) ? 32'(id) : 32'd0;
          default: e.dat = {29'd0, st2, (m_state == 1)};
        endcase
      end
      rsp_q.push_back(e);
    end
    @(posedge clk);
    if (rst_i) begin
      m_pend = '0; m_en = '0; m_prev = '0; m_claimed = 0; m_state = 0;
    end else begin
      edges = s & ~m_prev;
      w1c   = '0;
      clr   = '0;
      if (acc && ok && we && off == 0) w1c = d[N-1:0] & lane[N-1:0];
      if (acc && ok && we && off == 1) m_en = (m_en & ~lane[N-1:0]) | (d[N-1:0] & lane[N-1:0]);
      claim    = acc && ok && !we && off == 2 && m_state == 1 && id != 0;
      complete = acc && ok && we && off == 2 && m_state == 2 && int'(d[5:0]) == m_claimed;
      if (claim) clr[id-1] = 1'b1;
      case (m_state)
        0: if (act != 0) m_state = 1;
        1: begin
          if (claim) begin m_state = 2; m_claimed = id; end
          else if (act == 0) m_state = 0;
        end
        default: if (complete) begin
          m_claimed = 0;
          m_state   = (act != 0) ? 1 : 0;
        end
      endcase
      m_pend = (m_pend & ~w1c & ~clr) | edges;
      m_prev = s;
    end
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic wb(input logic we, input logic [31:0] adr, input logic [31:0] dat);
    req     = '0;
    req.cyc = 1'b1;
    req.stb = 1'b1;
    req.we  = we;
    req.sel = 4'hF;
    req.adr = adr;
    req.dat = dat;
    tick();
    req = '0;
  endtask

  task automatic pulse(input logic [N-1:0] v);
    src_i = v;
    tick();
    src_i = '0;
  endtask

  // Monitor: checks irq_o every cycle and each acknowledged bus access
  exp_t e_mon;
  logic irq_exp;
  initial begin
    forever begin
      @(negedge clk);
      if (irq_q.size() != 0) begin
        irq_exp = irq_q.pop_front();
        n_cmp++;
        if (irq_o !== irq_exp) begin
          n_bad++;
          $display("FAIL irq_o: got %0b want %0b at %0t", irq_o, irq_exp, $time);
        end
      end
      if (rsp.ack === 1'b1) begin
        n_cmp++;
        if (rsp_q.size() == 0) begin
          n_bad++;
          $display("FAIL spurious_ack: got ack=1 want no access at %0t", $time);
        end else begin
          e_mon = rsp_q.pop_front();
          if (rsp.err !== e_mon.err || rsp.dat !== e_mon.dat) begin
            n_bad++;
            $display("FAIL wb_rsp: got err=%0b dat=%h want err=%0b dat=%h at %0t",
                     rsp.err, rsp.dat, e_mon.err, e_mon.dat, $time);
          end
        end
      end
    end
  end

  initial begin
    rst_i = 1'b1; src_i = '0; req = '0;
    m_pend = '0; m_en = '0; m_prev = '0; m_claimed = 0; m_state = 0;
    @(posedge clk); #1;
    ticks(3);
    wb(0, 32'h0, 0); wb(0, 32'h4, 0); wb(0, 32'hC, 0);
    rst_i = 1'b0;
    tick();

    // single source, claim and complete
    wb(1, 32'h4, 32'h03);
    pulse(8'h02);
    wb(0, 32'h0, 0);
    wb(0, 32'h8, 0);
    wb(0, 32'h0, 0);
    wb(0, 32'hC, 0);
    wb(1, 32'h8, 32'd2);
    wb(0, 32'hC, 0);

    // two simultaneous edges serviced in priority order
    wb(1, 32'h4, 32'hFF);
    pulse(8'h21);
    ticks(2);
    wb(0, 32'h8, 0);
    wb(1, 32'h8, 32'd1);
    tick();
    wb(0, 32'h8, 0);
    wb(1, 32'h8, 32'd6);
    ticks(2);

    // W1C colliding with a fresh edge on the same bit
    pulse(8'h01);
    ticks(2);
    src_i = 8'h01;
    wb(1, 32'h0, 32'h01);
    src_i = '0;
    wb(0, 32'h0, 0);
    tick();
    wb(0, 32'h8, 0);
    wb(1, 32'h8, 32'd1);

    // pending but masked, then enabled, then disabled before claim
    wb(1, 32'h4, 32'h00);
    pulse(8'h08);
    ticks(2);
    wb(0, 32'h8, 0);
    wb(1, 32'h4, 32'h08);
    ticks(2);
    wb(1, 32'h4, 32'h00);
    ticks(2);
    wb(0, 32'hC, 0);
    wb(1, 32'h0, 32'hFF);

    // error address, wrong-ID complete
    wb(0, 32'h10, 0);
    wb(1, 32'h10, 32'hFF);
    wb(1, 32'h4, 32'h02);
    pulse(8'h02);
    ticks(2);
    wb(0, 32'h8, 0);
    wb(1, 32'h8, 32'd5);
    wb(0, 32'hC, 0);

    // reset mid-service with a source held high
    src_i = 8'h01;
    rst_i = 1'b1;
    tick();
    wb(0, 32'h0, 0);
    rst_i = 1'b0;
    tick();
    wb(0, 32'h0, 0);
    wb(0, 32'hC, 0);
    src_i = '0;
    tick();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(0, 7) == 0) src_i[b] = ~src_i[b];
      rst_i = ($urandom_range(0, 299) == 0);
      req = '0;
      if ($urandom_range(0, 1) == 1) begin
        req.cyc = 1'b1;
        req.stb = ($urandom_range(0, 9) != 0);
        req.we  = $urandom_range(0, 1) == 1;
        req.sel = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 15) == 0) req.adr = 32'($urandom_range(13, 40));
        else req.adr = 32'($urandom_range(0, 3)) << 2;
        req.dat = $urandom;
        if (req.adr == 32'h8 && $urandom_range(0, 3) != 0) req.dat = 32'(m_claimed);
        if (req.adr == 32'h4 && $urandom_range(0, 1) == 1) req.dat[N-1:0] = '1;
      end
      tick();
    end
    req = '0; rst_i = 1'b0; src_i = '0;
    ticks(2);

    n_cmp++;
    if (rsp_q.size() != 0) begin
      n_bad++;
      $display("FAIL missing_ack: got %0d responses outstanding want 0", rsp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
